// File: rtl/elevator_pkg.sv
// Shared constants, floor type and dwell FSM encoding for the elevator request path.
package elevator_pkg;

    localparam int FLOORS    = 10;
    localparam int FLOOR_MIN = 1;
    localparam int FLOOR_MAX = 10;

    typedef logic [3:0] floor_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } dwell_state_t;

endpackage

// File: rtl/key_debounce.sv
// One-key 2-flop synchronizer plus sample-counting debouncer driven by a shared tick.
// Latency: 2 sync cycles, then DEB_SAMPLES ticks of a stable level before key_level toggles.
// Backpressure: none; free-running.
module key_debounce
    import elevator_pkg::*;
#(
    parameter int DEB_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic key_raw,
    output logic key_level
);

    localparam int CW = $clog2(DEB_SAMPLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            cnt       <= '0;
            key_level <= 1'b0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            if (tick) begin
                if (sync2 != key_level) begin
                    // The DEB_SAMPLES-th consecutive differing sample flips the level.
                    if (cnt == CW'(DEB_SAMPLES - 1)) begin
                        key_level <= ~key_level;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/elevator_request_latch.sv
// Debounces ten floor keys into a pending-request vector, serves a floor with a timed door dwell.
// Latency: buttons set 1 cycle after key_level rises; door_open rises 1 cycle after a floor match.
// Backpressure: none. Optional macro ELEV_REQ_CANCEL_EN enables toggle-to-cancel of pending floors.
module elevator_request_latch
    import elevator_pkg::*;
#(
    parameter int DEB_DIV      = 1000,
    parameter int DEB_SAMPLES  = 4,
    parameter int DWELL_CYCLES = 50000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [FLOORS-1:0] key_in,
    input  floor_t            Layer,
    output logic [FLOORS-1:0] buttons,
    output logic              door_open,
    output logic [FLOORS-1:0] key_level
);

    localparam int DIVW = $clog2(DEB_DIV + 1);
    localparam int DCW  = $clog2(DWELL_CYCLES + 1);

    logic [DIVW-1:0]   div_cnt;
    logic              tick;
    logic [FLOORS-1:0] key_level_d;
    logic [FLOORS-1:0] rise;
    logic [FLOORS-1:0] set_vec;
    logic [FLOORS-1:0] clr_vec;
    logic [FLOORS-1:0] hold_mask;
    logic [FLOORS-1:0] buttons_nxt;

    dwell_state_t   state, state_nxt;
    floor_t         served, served_nxt;
    logic [DCW-1:0] dwell_cnt, dwell_cnt_nxt;
    logic           hit;
    floor_t         hit_idx;

    assign tick = (div_cnt == DIVW'(DEB_DIV - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < FLOORS; g++) begin : g_key
        key_debounce #(
            .DEB_SAMPLES(DEB_SAMPLES)
        ) u_deb (
            .clk      (CLK),
            .rst_n    (RST_N),
            .tick     (tick),
            .key_raw  (key_in[g]),
            .key_level(key_level[g])
        );
    end

    assign rise = key_level & ~key_level_d;

    // Layer values outside FLOOR_MIN..FLOOR_MAX find no bit and never match.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (Layer == floor_t'(i + FLOOR_MIN) && buttons[i]) begin
                hit     = 1'b1;
                hit_idx = floor_t'(i);
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        served_nxt    = served;
        dwell_cnt_nxt = dwell_cnt;
        clr_vec       = '0;
        hold_mask     = '0;
        door_open     = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    state_nxt     = DWELL;
                    served_nxt    = hit_idx;
                    dwell_cnt_nxt = DCW'(DWELL_CYCLES - 1);
                end
            end
            DWELL: begin
                door_open = 1'b1;
                for (int i = 0; i < FLOORS; i++) begin
                    hold_mask[i] = (served == floor_t'(i));
                end
                if (dwell_cnt == '0) begin
                    state_nxt = IDLE;
                    clr_vec   = hold_mask;
                end else begin
                    dwell_cnt_nxt = dwell_cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Presses of the floor being served are dropped so the dwell-end clear is final.
    assign set_vec = rise & ~hold_mask;

`ifdef ELEV_REQ_CANCEL_EN
    assign buttons_nxt = (buttons | (set_vec & ~buttons)) & ~(clr_vec | (set_vec & buttons));
`else
    assign buttons_nxt = (buttons | set_vec) & ~clr_vec;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            served      <= '0;
            dwell_cnt   <= '0;
            key_level_d <= '0;
            buttons     <= '0;
        end else begin
            state       <= state_nxt;
            served      <= served_nxt;
            dwell_cnt   <= dwell_cnt_nxt;
            key_level_d <= key_level;
            buttons     <= buttons_nxt;
        end
    end

endmodule

// File: tb/tb_elevator_request_latch.sv
// Directed, table-driven bench for elevator_request_latch with small debounce/dwell parameters.
module tb_elevator_request_latch;
    import elevator_pkg::*;

    localparam int DEB_DIV      = 4;
    localparam int DEB_SAMPLES  = 3;
    localparam int DWELL_CYCLES = 8;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic [FLOORS-1:0] key_in = '0;
    floor_t            Layer = '0;
    logic [FLOORS-1:0] buttons;
    logic              door_open;
    logic [FLOORS-1:0] key_level;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    elevator_request_latch #(
        .DEB_DIV     (DEB_DIV),
        .DEB_SAMPLES (DEB_SAMPLES),
        .DWELL_CYCLES(DWELL_CYCLES)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .key_in   (key_in),
        .Layer    (Layer),
        .buttons  (buttons),
        .door_open(door_open),
        .key_level(key_level)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic press(input logic [FLOORS-1:0] m);
        key_in = m;
        cycles(24);
        key_in = '0;
        cycles(24);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N  = 1'b0;
        key_in = '0;
        Layer  = '0;
        cycles(3);
        RST_N = 1'b1;
        cycles(2);
    endtask

    typedef struct {
        floor_t            layer;
        logic [FLOORS-1:0] press_mask;
        logic [FLOORS-1:0] exp_btn;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [FLOORS-1:0] exp;
        logic              seen;
        logic              found;
        logic              last_b5;
        int                hi;
        int                t_ref;
        int                c0;

        vecs[0] = '{4'd0,  10'h001, 10'h001};
        vecs[1] = '{4'd11, 10'h020, 10'h021};
        vecs[2] = '{4'd15, 10'h200, 10'h221};
        vecs[3] = '{4'd0,  10'h006, 10'h227};
        vecs[4] = '{4'd10, 10'h000, 10'h027};
        vecs[5] = '{4'd1,  10'h000, 10'h026};
        vecs[6] = '{4'd0,  10'h100, 10'h126};

        // Reset held with every key pressed.
        RST_N  = 1'b0;
        key_in = '1;
        cycles(5);
        check("rst_buttons",   32'(buttons),   32'h0);
        check("rst_door",      32'(door_open), 32'h0);
        check("rst_key_level", 32'(key_level), 32'h0);
        RST_N = 1'b1;
        cycles(8);
        check("rst_no_early_latch", 32'(buttons), 32'h0);
        cycles(22);
        check("rst_then_latched",   32'(buttons),   32'h3FF);
        check("rst_then_level",     32'(key_level), 32'h3FF);
        key_in = '0;
        cycles(30);

        // Invalid floors never match.
        seen  = 1'b0;
        Layer = 4'd0;
        repeat (10) begin
            @(negedge CLK);
            seen |= door_open;
        end
        check("inv0_door",    32'(seen),    32'h0);
        check("inv0_buttons", 32'(buttons), 32'h3FF);
        seen  = 1'b0;
        Layer = 4'd11;
        repeat (12) begin
            @(negedge CLK);
            seen |= door_open;
        end
        check("inv11_door",    32'(seen),    32'h0);
        check("inv11_buttons", 32'(buttons), 32'h3FF);

        // Asynchronous reset in the middle of a dwell.
        Layer = 4'd6;
        @(negedge CLK);
        check("dwell_start", 32'(door_open), 32'h1);
        cycles(2);
        #1 RST_N = 1'b0;
        #1;
        check("rst_mid_dwell_buttons", 32'(buttons),   32'h0);
        check("rst_mid_dwell_door",    32'(door_open), 32'h0);
        @(negedge CLK);
        Layer = '0;
        RST_N = 1'b1;
        cycles(2);

        for (int v = 0; v < 7; v++) begin
            Layer = vecs[v].layer;
            press(vecs[v].press_mask);
            check($sformatf("vec%0d_buttons", v), 32'(buttons),   32'(vecs[v].exp_btn));
            check($sformatf("vec%0d_door", v),    32'(door_open), 32'h0);
            check($sformatf("vec%0d_level", v),   32'(key_level), 32'h0);
        end

        // Serve floor 6 out of floors 1 and 6.
        do_reset();
        press(10'h021);
        check("serve_pre", 32'(buttons), 32'h021);
        Layer = 4'd6;
        @(negedge CLK);
        check("serve_door_rise", 32'(door_open), 32'h1);
        hi      = 1;
        last_b5 = buttons[5];
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (!door_open) break;
            hi++;
            last_b5 = buttons[5];
        end
        check("serve_door_cycles",   32'(hi),      32'd8);
        check("serve_held_in_dwell", 32'(last_b5), 32'h1);
        check("serve_after",         32'(buttons), 32'h001);
        Layer = '0;
        cycles(4);
        exp = 10'h001;

        // Floor 3 set lands on the same edge as floor 6 dwell-end clear.
        key_in[5] = 1'b1;
        found     = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge CLK);
            if (key_level[5]) found = 1'b1;
        end
        check("sim_ref_level", 32'(found), 32'h1);
        t_ref     = cyc;
        key_in[5] = 1'b0;
        @(negedge CLK);
        check("sim_b6_set", 32'(buttons[5]), 32'h1);
        for (int k = 0; k < 8; k++) begin
            if (((cyc + 3 - t_ref) % 4) == 0) break;
            @(negedge CLK);
        end
        c0        = cyc;
        key_in[2] = 1'b1;
        cycles(3);
        Layer = 4'd6;
        cycles(8);
        check("sim_pre_b3",   32'(buttons[2]), 32'h0);
        check("sim_pre_b6",   32'(buttons[5]), 32'h1);
        check("sim_pre_door", 32'(door_open),  32'h1);
        @(negedge CLK);
        check("sim_b3_set",   32'(buttons[2]), 32'h1);
        check("sim_b6_clr",   32'(buttons[5]), 32'h0);
        check("sim_door_low", 32'(door_open),  32'h0);
        check("sim_elapsed",  32'(cyc - c0),   32'd12);
        Layer  = '0;
        key_in = '0;
        cycles(30);
        exp = 10'h005;
        check("sim_final", 32'(buttons), 32'(exp));

        // Repeat press of pending floor 8.
        press(10'h080);
        exp |= 10'h080;
        check("cancel_first", 32'(buttons), 32'(exp));
        press(10'h080);
`ifdef ELEV_REQ_CANCEL_EN
        exp &= ~10'h080;
`endif
        check("cancel_second", 32'(buttons), 32'(exp));

        // Bouncing key 5 must not latch until it holds.
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) key_in[4] = ~key_in[4];
            @(negedge CLK);
            seen |= buttons[4];
        end
        key_in[4] = 1'b1;
        found     = 1'b0;
        for (int k = 1; k <= 19 && !found; k++) begin
            @(negedge CLK);
            if (buttons[4]) found = 1'b1;
        end
        check("bounce_quiet",     32'(seen),    32'h0);
        check("bounce_latched",   32'(found),   32'h1);
        check("bounce_others",    32'(buttons), 32'(exp | 10'h010));
        key_in = '0;
        cycles(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
